// File: rtl/lynx_mem_pkg.sv
// lynx_mem_pkg: shared constants for the Lynx external RAM path
// Provides the bridge FSM state codes, the external address width, the
// default ACCESS-state length and the CPU clock-enable slot length.
package lynx_mem_pkg;
    localparam int RAM_AW   = 23;
    localparam int RAM_WAIT = 2;
    localparam int CPU_SLOT = 8;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;
endpackage

// File: rtl/ram_req_latch.sv
// ram_req_latch: one-deep request holding register
// Ports:
//   clock, reset : system clock, async active-high reset
//   set, clr     : capture a request / retire the held request (set wins)
//   d, q         : request payload in / held payload out
//   vld          : a request is being held
//   ovr          : sticky, a set arrived while full and was dropped
// With OVERWRITE=1 a set while full replaces the held payload and ovr stays 0.
module ram_req_latch #(
    parameter int W         = 8,
    parameter bit OVERWRITE = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         set,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic         vld,
    output logic [W-1:0] q,
    output logic         ovr
);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld <= 1'b0;
            q   <= '0;
            ovr <= 1'b0;
        end else begin
            if (set && vld && !OVERWRITE) ovr <= 1'b1;
            if (set && (OVERWRITE || !vld)) begin
                vld <= 1'b1;
                q   <= d;
            end else if (clr) begin
                vld <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/ext_ram_bridge.sv
// ext_ram_bridge: timed external RAM cycles for the core plus a loader write port
// Ports:
//   clock, reset                       : system clock, async active-high reset
//   cpu_req/we/addr/wdata              : one-clock CPU access strobe and payload
//   cpu_rdata, cpu_ack                 : held read data, completion pulse
//   dl_wr/addr/data                    : loader write strobe and payload
//   dl_wait, dl_overrun                : loader back-pressure, sticky dropped-write flag
//   busy                               : bridge not idle
//   ram_addr/data_o/data_i/cs_o/oe_o/we_o : memory side
module ext_ram_bridge #(
    parameter int AW       = lynx_mem_pkg::RAM_AW,
    parameter int WAIT     = lynx_mem_pkg::RAM_WAIT,
    parameter int CPU_SLOT = lynx_mem_pkg::CPU_SLOT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_ack,
    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic [7:0]    dl_data,
    output logic          dl_wait,
    output logic          dl_overrun,
    output logic          busy,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_data_o,
    input  logic [7:0]    ram_data_i,
    output logic          ram_cs_o,
    output logic          ram_oe_o,
    output logic          ram_we_o
);
    import lynx_mem_pkg::*;
    localparam int WCW = $clog2(WAIT + 1);
    if (WAIT < 1 || WAIT > 4 || WAIT + 2 > CPU_SLOT - 1) begin : g_bad_cfg
        $error("ext_ram_bridge: WAIT must be 1..4 and SETUP+WAIT+HOLD must fit in CPU_SLOT-1");
    end
    logic [1:0]     state;
    logic [WCW-1:0] wcnt;
    logic           own_cpu;
    logic           rd;
    logic           last;
    logic           cpu_vld;
    logic           dl_vld;
    logic           cpu_ovr_unused;
    logic [AW+8:0]  cpu_in;
    logic [AW+8:0]  cpu_q;
    logic [AW+8:0]  cpu_sel;
    logic [AW+7:0]  dl_q;
    assign cpu_in  = {cpu_we, cpu_addr, cpu_wdata};
    // A strobe landing in IDLE is served straight away so the ack lands WAIT+2 clocks later.
    assign cpu_sel = cpu_req ? cpu_in : cpu_q;
    assign last    = wcnt == WCW'(WAIT - 1);
    assign dl_wait = dl_vld;
    // IDLE always consumes a pending CPU request, so the latch only fills while a cycle runs.
    ram_req_latch #(.W(AW + 9), .OVERWRITE(1'b1)) u_cpu_latch (
        .clock (clock),
        .reset (reset),
        .set   (cpu_req && state != IDLE),
        .clr   (state == IDLE),
        .d     (cpu_in),
        .vld   (cpu_vld),
        .q     (cpu_q),
        .ovr   (cpu_ovr_unused)
    );
    ram_req_latch #(.W(AW + 8), .OVERWRITE(1'b0)) u_dl_latch (
        .clock (clock),
        .reset (reset),
        .set   (dl_wr),
        .clr   (state == HOLD && !own_cpu),
        .d     ({dl_addr, dl_data}),
        .vld   (dl_vld),
        .q     (dl_q),
        .ovr   (dl_overrun)
    );
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wcnt       <= '0;
            own_cpu    <= 1'b0;
            rd         <= 1'b0;
            busy       <= 1'b0;
            ram_addr   <= '0;
            ram_data_o <= '0;
            ram_cs_o   <= 1'b0;
            ram_oe_o   <= 1'b0;
            ram_we_o   <= 1'b0;
            cpu_rdata  <= '0;
            cpu_ack    <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req || cpu_vld) begin
                        state      <= SETUP;
                        busy       <= 1'b1;
                        own_cpu    <= 1'b1;
                        rd         <= ~cpu_sel[AW+8];
                        ram_addr   <= cpu_sel[AW+7:8];
                        ram_data_o <= cpu_sel[7:0];
                        ram_cs_o   <= 1'b1;
                        ram_oe_o   <= ~cpu_sel[AW+8];
                    end else if (dl_vld) begin
                        state      <= SETUP;
                        busy       <= 1'b1;
                        own_cpu    <= 1'b0;
                        rd         <= 1'b0;
                        ram_addr   <= dl_q[AW+7:8];
                        ram_data_o <= dl_q[7:0];
                        ram_cs_o   <= 1'b1;
                        ram_oe_o   <= 1'b0;
                    end
                end
                SETUP: begin
                    state    <= ACCESS;
                    wcnt     <= '0;
                    ram_we_o <= ~rd;
                end
                ACCESS: begin
                    if (last) begin
                        state    <= HOLD;
                        ram_we_o <= 1'b0;
                        ram_oe_o <= 1'b0;
                        cpu_ack  <= own_cpu;
                        if (rd) cpu_rdata <= ram_data_i;
                    end else begin
                        wcnt <= wcnt + WCW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    ram_cs_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ext_ram_bridge.sv
// tb_ext_ram_bridge: directed vector bench for ext_ram_bridge (WAIT=2 and WAIT=4 instances)
module tb_ext_ram_bridge;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, dl_wr = 1'b0;
    logic [22:0] cpu_addr = '0, dl_addr = '0;
    logic [7:0]  cpu_wdata = '0, dl_data = '0;
    logic [7:0]  cpu_rdata, ram_data_o, ram_data_i;
    logic [22:0] ram_addr;
    logic        cpu_ack, dl_wait, dl_overrun, busy, ram_cs_o, ram_oe_o, ram_we_o;
    logic        b_req = 1'b0, b_we = 1'b0, b_dl_wr = 1'b0;
    logic [22:0] b_addr = '0, b_dl_addr = '0;
    logic [7:0]  b_wdata = '0, b_dl_data = '0;
    logic [7:0]  b_rdata, b_data_o, b_data_i;
    logic [22:0] b_ram_addr;
    logic        b_ack, b_dl_wait, b_dl_overrun, b_busy, b_cs, b_oe, b_we_o;
    int total = 0;
    int bad = 0;
    always #5 clock = ~clock;
    ext_ram_bridge #(.AW(23), .WAIT(2), .CPU_SLOT(8)) u_dut (
        .clock(clock), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data), .dl_wait(dl_wait), .dl_overrun(dl_overrun),
        .busy(busy), .ram_addr(ram_addr), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i),
        .ram_cs_o(ram_cs_o), .ram_oe_o(ram_oe_o), .ram_we_o(ram_we_o)
    );
    ext_ram_bridge #(.AW(23), .WAIT(4), .CPU_SLOT(8)) u_dut4 (
        .clock(clock), .reset(reset), .cpu_req(b_req), .cpu_we(b_we), .cpu_addr(b_addr),
        .cpu_wdata(b_wdata), .cpu_rdata(b_rdata), .cpu_ack(b_ack), .dl_wr(b_dl_wr),
        .dl_addr(b_dl_addr), .dl_data(b_dl_data), .dl_wait(b_dl_wait), .dl_overrun(b_dl_overrun),
        .busy(b_busy), .ram_addr(b_ram_addr), .ram_data_o(b_data_o), .ram_data_i(b_data_i),
        .ram_cs_o(b_cs), .ram_oe_o(b_oe), .ram_we_o(b_we_o)
    );
    logic [7:0] mem [0:262143];
    logic [7:0] mem4 [0:16383];
    logic bad_wr = 1'b0;
    initial begin
        mem[18'h04000] <= 8'h3C;
        mem[18'h00010] <= 8'h77;
    end
    always @(posedge clock) begin
        if (ram_cs_o && ram_we_o) begin
            mem[ram_addr[17:0]] <= ram_data_o;
            if (ram_addr == 23'h30001 || ram_data_o == 8'h22) bad_wr <= 1'b1;
        end
        if (b_cs && b_we_o) mem4[b_ram_addr[13:0]] <= b_data_o;
    end
    always_comb ram_data_i = (ram_cs_o && ram_oe_o) ? mem[ram_addr[17:0]] : 8'h00;
    always_comb b_data_i = (b_cs && b_oe) ? mem4[b_ram_addr[13:0]] : 8'h00;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask
    typedef struct {
        logic        req, we;
        logic [22:0] addr;
        logic [7:0]  wd;
        logic        dw;
        logic [22:0] da;
        logic [7:0]  dd;
        logic [5:0]  f;
        logic [22:0] ea;
        logic [7:0]  ed, er;
    } vec_t;
    vec_t vt[$];
    task automatic row(input logic rq, input logic w, input logic [22:0] a, input logic [7:0] wd,
                       input logic dw, input logic [22:0] da, input logic [7:0] dd,
                       input logic [5:0] f, input logic [22:0] ea, input logic [7:0] ed, input logic [7:0] er);
        vec_t x;
        x.req = rq; x.we = w; x.addr = a; x.wd = wd; x.dw = dw; x.da = da; x.dd = dd;
        x.f = f; x.ea = ea; x.ed = ed; x.er = er;
        vt.push_back(x);
    endtask
    task automatic e(input logic [5:0] f, input logic [22:0] ea, input logic [7:0] ed, input logic [7:0] er);
        row(1'b0, 1'b0, 23'h0, 8'h0, 1'b0, 23'h0, 8'h0, f, ea, ed, er);
    endtask
    initial begin
        int lat, ack_seen, busy_seen;
        logic [22:0] a;
        logic [7:0] d;
        #100_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int lat, ack_seen, busy_seen;
        logic [22:0] a;
        logic [7:0] d;
        // flags = {cs, oe, we, ack, busy, dl_wait}
        row(1, 1, 23'h01234, 8'hA5, 0, 0, 0, 6'b000000, 23'h0, 8'h00, 8'h00);
        e(6'b100010, 23'h01234, 8'hA5, 8'h00);
        e(6'b101010, 23'h01234, 8'hA5, 8'h00);
        e(6'b101010, 23'h01234, 8'hA5, 8'h00);
        e(6'b100110, 23'h01234, 8'hA5, 8'h00);
        e(6'b000000, 23'h01234, 8'hA5, 8'h00);
        row(1, 0, 23'h04000, 8'h00, 0, 0, 0, 6'b000000, 23'h01234, 8'hA5, 8'h00);
        e(6'b110010, 23'h04000, 8'h00, 8'h00);
        e(6'b110010, 23'h04000, 8'h00, 8'h00);
        e(6'b110010, 23'h04000, 8'h00, 8'h00);
        e(6'b100110, 23'h04000, 8'h00, 8'h3C);
        e(6'b000000, 23'h04000, 8'h00, 8'h3C);
        row(1, 0, 23'h00010, 8'h00, 1, 23'h20000, 8'h55, 6'b000000, 23'h04000, 8'h00, 8'h3C);
        e(6'b110011, 23'h00010, 8'h00, 8'h3C);
        e(6'b110011, 23'h00010, 8'h00, 8'h3C);
        e(6'b110011, 23'h00010, 8'h00, 8'h3C);
        e(6'b100111, 23'h00010, 8'h00, 8'h77);
        e(6'b000001, 23'h00010, 8'h00, 8'h77);
        e(6'b100011, 23'h20000, 8'h55, 8'h77);
        e(6'b101011, 23'h20000, 8'h55, 8'h77);
        e(6'b101011, 23'h20000, 8'h55, 8'h77);
        e(6'b100011, 23'h20000, 8'h55, 8'h77);
        e(6'b000000, 23'h20000, 8'h55, 8'h77);
        #1 reset = 1'b1;
        #2;
        chk("reset outputs", {ram_cs_o, ram_oe_o, ram_we_o, cpu_ack, busy, dl_wait, dl_overrun}, 0);
        chk("reset addr/data/rdata", {ram_addr, ram_data_o, cpu_rdata}, 0);
        chk("reset dut4 outputs", {b_cs, b_oe, b_we_o, b_ack, b_busy, b_dl_wait, b_dl_overrun, b_ram_addr}, 0);
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        for (int i = 0; i < vt.size(); i++) begin
            @(posedge clock);
            #1;
            cpu_req = vt[i].req; cpu_we = vt[i].we; cpu_addr = vt[i].addr; cpu_wdata = vt[i].wd;
            dl_wr = vt[i].dw; dl_addr = vt[i].da; dl_data = vt[i].dd;
            @(negedge clock);
            chk($sformatf("vec%0d flags", i), {ram_cs_o, ram_oe_o, ram_we_o, cpu_ack, busy, dl_wait}, vt[i].f);
            chk($sformatf("vec%0d ram_addr", i), ram_addr, vt[i].ea);
            chk($sformatf("vec%0d ram_data_o", i), ram_data_o, vt[i].ed);
            chk($sformatf("vec%0d cpu_rdata", i), cpu_rdata, vt[i].er);
        end
        chk("mem write cpu", mem[18'h01234], 8'hA5);
        chk("mem write loader", mem[18'h20000], 8'h55);
        // loader overrun: second strobe while dl_wait is high must be dropped
        @(posedge clock); #1 dl_wr = 1; dl_addr = 23'h30000; dl_data = 8'h11;
        @(posedge clock); #1 dl_addr = 23'h30001; dl_data = 8'h22;
        @(negedge clock);
        chk("dl_wait after strobe", dl_wait, 1);
        chk("no overrun yet", dl_overrun, 0);
        @(posedge clock); #1 dl_wr = 0;
        @(negedge clock);
        chk("overrun set", dl_overrun, 1);
        for (int n = 0; n < 20 && dl_wait; n++) @(negedge clock);
        chk("dl_wait drained", dl_wait, 0);
        chk("first loader write stored", mem[18'h30000], 8'h11);
        chk("second loader write never driven", bad_wr, 0);
        @(posedge clock); #1 cpu_req = 1; cpu_we = 0; cpu_addr = 23'h30000;
        @(posedge clock); #1 cpu_req = 0;
        ack_seen = 0;
        for (int n = 0; n < 10 && !ack_seen; n++) begin
            @(negedge clock);
            if (cpu_ack) ack_seen = 1;
        end
        chk("readback ack", ack_seen, 1);
        chk("readback loader data", cpu_rdata, 8'h11);
        chk("overrun sticky", dl_overrun, 1);
        // reset in the middle of a write ACCESS
        repeat (2) @(posedge clock);
        #1 cpu_req = 1; cpu_we = 1; cpu_addr = 23'h00100; cpu_wdata = 8'h99;
        @(posedge clock); #1 cpu_req = 0;
        @(posedge clock);
        @(negedge clock);
        chk("write in access", {ram_cs_o, ram_we_o}, 2'b11);
        #2 reset = 1'b1;
        #1;
        chk("async reset drops strobes", {ram_cs_o, ram_we_o, busy}, 0);
        chk("reset clears overrun", dl_overrun, 0);
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        ack_seen = 0; busy_seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            if (cpu_ack) ack_seen = 1;
            if (busy) busy_seen = 1;
        end
        chk("no ack after reset", ack_seen, 0);
        chk("idle after reset", busy_seen, 0);
        // WAIT=4 back-to-back traffic, one request per 8-clock slot
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 256; i++) begin
                a = 23'(i * 37 + 'h100);
                d = 8'(i * 7 + 3);
                @(posedge clock);
                #1 b_req = 1; b_we = (p == 0); b_addr = a; b_wdata = (p == 0) ? d : 8'h00;
                @(negedge clock);
                chk($sformatf("slot p%0d i%0d busy at req", p, i), b_busy, 0);
                lat = 0;
                for (int k = 1; k <= 7; k++) begin
                    @(posedge clock);
                    #1 b_req = 0;
                    @(negedge clock);
                    if (b_ack) lat = (lat == 0) ? k : 99;
                end
                chk($sformatf("slot p%0d i%0d ack latency", p, i), lat, 6);
                if (p == 1) chk($sformatf("slot i%0d read data", i), b_rdata, d);
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ext_ram_bridge.md
Name: ext_ram_bridge

Overview:
- Sits directly downstream of the Lynx core's external RAM port (ram_addr / ram_data_o / ram_data_i / ram_cs_o / ram_oe_o / ram_we_o).
- Turns the core's one-clock memory strobe into a timed async-SRAM/SDRAM-controller cycle, and returns latched read data well inside one CPU clock-enable period.
- Also gives the download/loader path (ROM and tape image load) a second, lower-priority write port, with arbitration and back-pressure.

Parameters:
- AW, 23, external address width.
- WAIT, 2, ACCESS-state cycles (1..4); sets memory strobe width.
- CPU_SLOT, 8, clocks between CPU strobes; check only: SETUP+WAIT+HOLD must be ≤ CPU_SLOT-1.

Ports:
- clock  in  1  system clock (same clock as the core).
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  one-clock access strobe (the core's ce4p-qualified request).
- cpu_we  in  1  1=write, 0=read; sampled with cpu_req.
- cpu_addr  in  AW  address, sampled with cpu_req.
- cpu_wdata  in  8  write data, sampled with cpu_req.
- cpu_rdata  out  8  read data; held until the next completed CPU read.
- cpu_ack  out  1  one-clock pulse when a CPU access completes.
- dl_wr  in  1  loader write strobe, one clock.
- dl_addr  in  AW  loader address.
- dl_data  in  8  loader data.
- dl_wait  out  1  high while a loader write is pending or in flight; loader must not strobe while high.
- dl_overrun  out  1  sticky; set if dl_wr arrives while dl_wait=1.
- busy  out  1  high in any state other than IDLE.
- ram_addr  out  AW  memory address.
- ram_data_o  out  8  memory write data.
- ram_data_i  in  8  memory read data.
- ram_cs_o  out  1  chip select, active high.
- ram_oe_o  out  1  output enable, active high.
- ram_we_o  out  1  write enable, active high.

Behaviour:
- Reset (async, immediate), all outputs 0:
  - state=IDLE; ram_addr=0, ram_data_o=0, ram_cs_o/oe_o/we_o=0.
  - cpu_rdata=0, cpu_ack=0, dl_wait=0, dl_overrun=0, busy=0.
  - Loader pending latch cleared.
  - Reset mid-access aborts the access; no ack is issued after reset is released.
- State machine: IDLE -> SETUP -> ACCESS (WAIT cycles, counted by wcnt) -> HOLD -> IDLE. All outputs are registered.
- Request capture and arbitration:
  - cpu_req in any state is captured into a one-deep CPU request latch (addr/we/wdata).
  - dl_wr is captured into a separate loader latch; dl_wait=1 from the next clock.
  - IDLE with a CPU latch set: start the CPU cycle.
  - Otherwise, IDLE with a loader latch set: start the loader cycle (always a write).
  - CPU always wins. A simultaneous cpu_req and dl_wr serves the CPU first; the loader is served on the following IDLE.
- SETUP (1 clk):
  - Drive ram_addr and ram_data_o.
  - ram_cs_o=1; ram_oe_o = read ? 1 : 0; ram_we_o=0.
- ACCESS (WAIT clks):
  - cs held; write cycles assert ram_we_o=1.
  - On the last ACCESS clock of a read, capture ram_data_i into cpu_rdata.
- HOLD (1 clk):
  - ram_we_o=0, ram_oe_o=0, ram_cs_o=1.
  - addr/data held so address and data hold time is met after WE falls.
  - cpu_ack=1 for CPU cycles; for loader cycles, clear the latch and drop dl_wait.
- IDLE: ram_cs_o=0; ram_addr and ram_data_o keep their last values.
- Latency: cpu_ack is asserted WAIT+2 clocks after the cpu_req clock (default 4). It is 7 clocks worst case if the CPU arrives while a loader cycle is already in ACCESS, which is still < CPU_SLOT.
- cpu_req arriving while the CPU latch is still set: the new request overwrites the latch. This is a core protocol error and is not flagged.
- dl_wr while dl_wait=1: the data is ignored and dl_overrun sets; it clears only on reset.
- WAIT wrap: wcnt is sized ceil(log2(WAIT+1)) and counts from 0 to WAIT-1.

Decomposition:
- Shared package lynx_mem_pkg:
  - state enum (IDLE, SETUP, ACCESS, HOLD).
  - RAM_AW=23.
  - default WAIT.
  - CPU_SLOT constant (8, matching the 3-bit ce divider).
- One natural sub-module, ram_req_latch: a one-deep request holding register with set/clear/overrun. It is instantiated twice, for the CPU and the loader.
- The arbiter FSM stays in the top module.

Test Plan:
- CPU write, addr 0x01234, data 0xA5, WAIT=2:
  - ram_cs_o rises 1 clk after cpu_req.
  - ram_we_o high for clks 2–3.
  - ram_addr=0x01234 and ram_data_o=0xA5 stable from SETUP through HOLD.
  - cpu_ack at clk 4.
- CPU read, addr 0x04000, memory model returns 0x3C:
  - ram_oe_o high for SETUP+ACCESS.
  - cpu_rdata=0x3C from the clock after the last ACCESS clock.
  - cpu_ack at clk 4; we never asserted.
- Simultaneous cpu_req (read 0x0010) and dl_wr (0x20000, 0x55):
  - CPU cycle runs first, ack at clk 4.
  - Loader write starts at clk 5; dl_wait falls after its HOLD (clk 9).
- Loader writes 0x11, then dl_wr again while dl_wait=1:
  - The second write is never driven to memory.
  - dl_overrun=1 and stays 1 until reset.
- Reset asserted during ACCESS of a write:
  - ram_we_o and ram_cs_o drop asynchronously, with no clock edge needed.
  - After release: no cpu_ack, state IDLE, busy=0.
- Back-to-back CPU requests every 8 clocks for 256 writes then 256 reads at WAIT=4:
  - Every read returns the written data.
  - ack arrives 6 clocks after each request.
  - busy is never high when the next cpu_req arrives.
